// File: rtl/axi_sram_slave_if.sv
// AXI3 channel bundle (AR/R/AW/W/B) between a master and the axi_sram_slave responder.
`timescale 1ns/1ps
interface axi_sram_slave_if #(
    parameter int ID_W = 4
) ();
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 SRAM responder with independent single-outstanding read and write engines.
// Define AXI_SRAM_ERRRESP_EN to answer out-of-window beats with SLVERR instead of aliasing.
`timescale 1ns/1ps
module axi_sram_slave #(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter int          ID_W      = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi_sram_slave_if.slave  axi
);

    typedef enum logic       {R_IDLE, R_DATA} rstate_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] addr);
        return MEM_AW'((addr - BASE_ADDR) >> 2);
    endfunction

`ifdef AXI_SRAM_ERRRESP_EN
    function automatic logic in_range(input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (addr >= BASE_ADDR) && (off < (33'd4 << MEM_AW));
    endfunction
`endif

    // WRAP only wraps for legal lengths; anything else degrades to INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [3:0] len);
        logic [31:0] inc;
        logic [31:0] mask;
        logic [31:0] res;
        inc  = addr + (32'd1 << size);
        mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        res  = inc;
        if (burst == 2'b00)
            res = addr;
        else if (burst == 2'b10 && (len inside {4'd1, 4'd3, 4'd7, 4'd15}))
            res = (addr & ~mask) | (inc & mask);
        return res;
    endfunction

    rstate_e         rstate_q, rstate_d;
    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic            rlast_q, rlast_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [3:0]      rcnt_q, rcnt_d;
    logic [31:0]     raddr_q, raddr_d;
    logic [3:0]      rlen_q, rlen_d;
    logic [2:0]      rsize_q, rsize_d;
    logic [1:0]      rburst_q, rburst_d;
    logic [31:0]     rbeat_addr;
    logic            rload;

    wstate_e         wstate_q, wstate_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            werr_q, werr_d;
    logic [31:0]     waddr_q, waddr_d;
    logic [3:0]      wlen_q, wlen_d;
    logic [2:0]      wsize_q, wsize_d;
    logic [1:0]      wburst_q, wburst_d;
    logic            wbeat_err;
    logic            mem_we;
    logic [MEM_AW-1:0] widx;

    // Read engine: rdata is registered from the array, so a same-cycle write is seen next beat.
    always_comb begin
        rstate_d   = rstate_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rcnt_d     = rcnt_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rbeat_addr = raddr_q;
        rload      = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi.arvalid && arready_q) begin
                    rstate_d   = R_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rid_d      = axi.arid;
                    raddr_d    = axi.araddr;
                    rlen_d     = axi.arlen[3:0];
                    rsize_d    = axi.arsize;
                    rburst_d   = axi.arburst;
                    rcnt_d     = 4'd0;
                    rlast_d    = (axi.arlen[3:0] == 4'd0);
                    rbeat_addr = axi.araddr;
                    rload      = 1'b1;
                end
            end
            default: begin
                if (axi.rready) begin
                    if (rlast_q) begin
                        rstate_d  = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rdata_d   = 32'd0;
                        rresp_d   = 2'b00;
                        arready_d = 1'b1;
                    end else begin
                        raddr_d    = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
                        rcnt_d     = rcnt_q + 4'd1;
                        rlast_d    = ((rcnt_q + 4'd1) == rlen_q);
                        rbeat_addr = raddr_d;
                        rload      = 1'b1;
                    end
                end
            end
        endcase
        if (rload) begin
            rdata_d = mem[word_idx(rbeat_addr)];
            rresp_d = 2'b00;
`ifdef AXI_SRAM_ERRRESP_EN
            if (!in_range(rbeat_addr)) begin
                rdata_d = 32'd0;
                rresp_d = 2'b10;
            end
`endif
        end
    end

    // Write engine: W beats are only taken once the AW handshake has set up the burst.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        werr_d    = werr_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        mem_we    = 1'b0;
`ifdef AXI_SRAM_ERRRESP_EN
        wbeat_err = !in_range(waddr_q);
`else
        wbeat_err = 1'b0;
`endif
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                werr_d    = 1'b0;
                if (axi.awvalid && awready_q) begin
                    wstate_d  = W_DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = axi.awid;
                    waddr_d   = axi.awaddr;
                    wlen_d    = axi.awlen[3:0];
                    wsize_d   = axi.awsize;
                    wburst_d  = axi.awburst;
                end
            end
            W_DATA: begin
                if (axi.wvalid && wready_q) begin
                    mem_we  = !wbeat_err;
                    werr_d  = werr_q | wbeat_err;
                    waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
                    if (axi.wlast) begin
                        wstate_d = W_RESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (werr_q | wbeat_err) ? 2'b10 : 2'b00;
                    end
                end
            end
            default: begin
                if (axi.bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = 2'b00;
                    awready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rcnt_q    <= 4'd0;
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            werr_q    <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rcnt_q    <= rcnt_d;
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            werr_q    <= werr_d;
        end
    end

    // Burst descriptors are only meaningful while their engine is busy, so they skip reset.
    always_ff @(posedge aclk) begin
        raddr_q  <= raddr_d;
        rlen_q   <= rlen_d;
        rsize_q  <= rsize_d;
        rburst_q <= rburst_d;
        waddr_q  <= waddr_d;
        wlen_q   <= wlen_d;
        wsize_q  <= wsize_d;
        wburst_q <= wburst_d;
    end

    assign widx = word_idx(waddr_q);

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) mem[widx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{axi.arlock, axi.arcache, axi.arprot, axi.arlen[7:4],
                         axi.awlock, axi.awcache, axi.awprot, axi.awlen[7:4], axi.wid};

endmodule
